// File: rtl/dmem_arbiter_if.sv
// Shared data-memory port bundle: core request, host request and RAM side.
// slave = arbiter view, master = the surrounding system (core/host/RAM).
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-RAM port between the ARM core (fixed
// priority) and an external host loader/reader served on idle core cycles.
// Read data returns one cycle after issue and is steered by rd_pend/rd_owner.
// Optional macro ARB_STARVE_GUARD_EN: after STARVE_MAX consecutive denied host
// cycles the host is granted for one cycle and the core is stalled.
module dmem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 8
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
    $error("dmem_arbiter: STARVE_MAX must be in 1..255");
  end

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  logic              rd_pend_q, rd_pend_d;
  owner_e            rd_owner_q, rd_owner_d;
  logic              cpu_gnt, host_gnt, force_host;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              cpu_rvalid, host_rvalid;

`ifdef ARB_STARVE_GUARD_EN
  logic [7:0] starve_cnt_q, starve_cnt_d;

  // Host wins outright once it has waited STARVE_MAX cycles
  always_comb force_host = bus.host_req && (starve_cnt_q == 8'(STARVE_MAX));

  // Count consecutive denied host cycles; any grant or idle host clears it
  always_comb begin
    starve_cnt_d = '0;
    if (!reset && bus.host_req && !host_gnt) starve_cnt_d = starve_cnt_q + 8'd1;
  end

  // Starve counter register
  always_ff @(posedge clk) begin
    if (reset) starve_cnt_q <= '0;
    else       starve_cnt_q <= starve_cnt_d;
  end
`else
  // Without the guard the core always wins
  always_comb force_host = 1'b0;
`endif

  // Grant selection, winner mux and next read-return tracking state
  always_comb begin
    cpu_gnt    = 1'b0;
    host_gnt   = 1'b0;
    win_we     = 1'b0;
    win_addr   = '0;
    win_wdata  = '0;
    if (!reset) begin
      if (force_host)        host_gnt = 1'b1;
      else if (bus.cpu_req)  cpu_gnt  = 1'b1;
      else if (bus.host_req) host_gnt = 1'b1;
    end
    if (cpu_gnt) begin
      win_we    = bus.cpu_we;
      win_addr  = bus.cpu_addr;
      win_wdata = bus.cpu_wdata;
    end else if (host_gnt) begin
      win_we    = bus.host_we;
      win_addr  = bus.host_addr;
      win_wdata = bus.host_wdata;
    end
    rd_pend_d  = (cpu_gnt | host_gnt) & ~win_we;
    rd_owner_d = host_gnt ? OWN_HOST : OWN_CPU;
  end

  // Read-return tracking registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= OWN_CPU;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Steer returning RAM data to the requester that issued the read
  always_comb begin
    cpu_rvalid  = rd_pend_q && (rd_owner_q == OWN_CPU)  && !reset;
    host_rvalid = rd_pend_q && (rd_owner_q == OWN_HOST) && !reset;
  end

  assign bus.cpu_gnt     = cpu_gnt;
  assign bus.cpu_stall   = bus.cpu_req & ~cpu_gnt & ~reset;
  assign bus.host_gnt    = host_gnt;
  assign bus.cpu_rvalid  = cpu_rvalid;
  assign bus.host_rvalid = host_rvalid;
  assign bus.cpu_rdata   = cpu_rvalid  ? bus.mem_rdata : '0;
  assign bus.host_rdata  = host_rvalid ? bus.mem_rdata : '0;
  assign bus.mem_en      = cpu_gnt | host_gnt;
  assign bus.mem_we      = win_we;
  assign bus.mem_addr    = win_addr;
  assign bus.mem_wdata   = win_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus a randomized mix, with a
// read-return scoreboard fed from a bench-side reference memory.
module tb_dmem_arbiter;
`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned TB_STARVE = 4;
`else
  localparam int unsigned TB_STARVE = 8;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(TB_STARVE)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Synchronous RAM model behind the arbiter
  logic [31:0] ram [logic [31:0]];
  logic [31:0] ram_rdata = '0;
  assign bus.mem_rdata = ram_rdata;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
      else ram_rdata <= ram.exists(bus.mem_addr) ? ram[bus.mem_addr] : 32'h0;
    end
  end

  typedef struct {
    logic        host;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] ref_mem [logic [31:0]];
  int          checks = 0;
  int          failures = 0;

  logic [4:0] ctl;  // {cpu_gnt, cpu_stall, host_gnt, mem_en, mem_we}
  logic [1:0] rv;   // {cpu_rvalid, host_rvalid}
  assign ctl = {bus.cpu_gnt, bus.cpu_stall, bus.host_gnt, bus.mem_en, bus.mem_we};
  assign rv  = {bus.cpu_rvalid, bus.host_rvalid};

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic hr, input logic hw, input logic [31:0] ha, input logic [31:0] hd);
    bus.cpu_req = cr;  bus.cpu_we = cw;  bus.cpu_addr = ca;  bus.cpu_wdata = cd;
    bus.host_req = hr; bus.host_we = hw; bus.host_addr = ha; bus.host_wdata = hd;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1, 0, 32'h40, 32'h0, 1, 1, 32'h44, 32'h1);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({ctl, rv, bus.cpu_rdata, bus.host_rdata, bus.mem_addr, bus.mem_wdata} !== '0) begin
        failures++;
        $display("FAIL reset_hold[%0d] ctl=%b rv=%b addr=%h wdata=%h (all required 0)",
                 i, ctl, rv, bus.mem_addr, bus.mem_wdata);
      end
    end
    step();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      #2;
      checks++;
      if ({ctl, rv, bus.cpu_rdata, bus.host_rdata, bus.mem_addr, bus.mem_wdata} !== '0) begin
        failures++;
        $display("FAIL reset_idle[%0d] ctl=%b rv=%b addr=%h (all required 0)", i, ctl, rv, bus.mem_addr);
      end
      step();
    end
  endtask

  task automatic test_core_rw();
    exp_t e;
    drive(1, 1, 32'h40, 32'hDEADBEEF, 0, 0, 0, 0);
    ref_mem[32'h40] = 32'hDEADBEEF;
    #2;
    checks++;
    if (ctl !== 5'b10011 || bus.mem_addr !== 32'h40 || bus.mem_wdata !== 32'hDEADBEEF || rv !== 2'b00) begin
      failures++;
      $display("FAIL core_write ctl=%b addr=%h wdata=%h rv=%b required ctl=10011 addr=40 wdata=deadbeef rv=00",
               ctl, bus.mem_addr, bus.mem_wdata, rv);
    end
    step();
    drive(1, 0, 32'h40, 32'h0, 0, 0, 0, 0);
    e.host = 1'b0; e.data = ref_rd(32'h40); exp_q.push_back(e);
    #2;
    checks++;
    if (ctl !== 5'b10010 || bus.mem_addr !== 32'h40 || rv !== 2'b00) begin
      failures++;
      $display("FAIL core_read_issue ctl=%b addr=%h rv=%b required ctl=10010 addr=40 rv=00", ctl, bus.mem_addr, rv);
    end
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    e = exp_q.pop_front();
    checks++;
    if (rv !== 2'b10 || bus.cpu_rdata !== e.data || bus.host_rdata !== 32'h0 || ctl !== 5'b00000) begin
      failures++;
      $display("FAIL core_read_return rv=%b rdata=%h ctl=%b required rv=10 rdata=%h ctl=00000",
               rv, bus.cpu_rdata, ctl, e.data);
    end
  endtask

  task automatic test_interleave();
    exp_t e;
    step();
    drive(1, 0, 32'h10, 32'h0, 0, 0, 0, 0);
    e.host = 1'b0; e.data = ref_rd(32'h10); exp_q.push_back(e);
    #2;
    checks++;
    if (ctl !== 5'b10010 || bus.mem_addr !== 32'h10) begin
      failures++;
      $display("FAIL ilv_c1 ctl=%b addr=%h required ctl=10010 addr=10", ctl, bus.mem_addr);
    end
    step();
    drive(0, 0, 0, 0, 1, 1, 32'h20, 32'h55);
    ref_mem[32'h20] = 32'h55;
    #2;
    e = exp_q.pop_front();
    checks++;
    if (rv !== 2'b10 || bus.cpu_rdata !== e.data || ctl !== 5'b00111 ||
        bus.mem_addr !== 32'h20 || bus.mem_wdata !== 32'h55) begin
      failures++;
      $display("FAIL ilv_c2 rv=%b rdata=%h ctl=%b addr=%h wdata=%h required rv=10 rdata=%h ctl=00111 addr=20 wdata=55",
               rv, bus.cpu_rdata, ctl, bus.mem_addr, bus.mem_wdata, e.data);
    end
    step();
    drive(1, 0, 32'h20, 32'h0, 0, 0, 0, 0);
    e.host = 1'b0; e.data = ref_rd(32'h20); exp_q.push_back(e);
    #2;
    checks++;
    if (rv !== 2'b00 || ctl !== 5'b10010) begin
      failures++;
      $display("FAIL ilv_c3 rv=%b ctl=%b required rv=00 ctl=10010", rv, ctl);
    end
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    e = exp_q.pop_front();
    checks++;
    if (rv !== 2'b10 || bus.cpu_rdata !== e.data || bus.cpu_rdata !== 32'h55) begin
      failures++;
      $display("FAIL ilv_c4 rv=%b rdata=%h required rv=10 rdata=%h", rv, bus.cpu_rdata, e.data);
    end
  endtask

  task automatic test_collision();
    exp_t e;
    step();
    drive(1, 0, 32'h40, 32'h0, 1, 0, 32'h20, 32'h0);
    e.host = 1'b0; e.data = ref_rd(32'h40); exp_q.push_back(e);
    #2;
    checks++;
    if (ctl !== 5'b10010 || bus.mem_addr !== 32'h40) begin
      failures++;
      $display("FAIL coll_c1 ctl=%b addr=%h required ctl=10010 addr=40", ctl, bus.mem_addr);
    end
    step();
    drive(0, 0, 0, 0, 1, 0, 32'h20, 32'h0);
    #2;
    e = exp_q.pop_front();
    checks++;
    if (ctl !== 5'b00110 || bus.mem_addr !== 32'h20 || rv !== 2'b10 ||
        bus.cpu_rdata !== e.data || bus.host_rdata !== 32'h0) begin
      failures++;
      $display("FAIL coll_c2 ctl=%b addr=%h rv=%b crdata=%h hrdata=%h required ctl=00110 addr=20 rv=10 crdata=%h hrdata=0",
               ctl, bus.mem_addr, rv, bus.cpu_rdata, bus.host_rdata, e.data);
    end
    e.host = 1'b1; e.data = ref_rd(32'h20); exp_q.push_back(e);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    e = exp_q.pop_front();
    checks++;
    if (rv !== 2'b01 || bus.host_rdata !== e.data || bus.cpu_rdata !== 32'h0) begin
      failures++;
      $display("FAIL coll_c3 rv=%b hrdata=%h crdata=%h required rv=01 hrdata=%h crdata=0",
               rv, bus.host_rdata, bus.cpu_rdata, e.data);
    end
  endtask

  task automatic test_starve();
    int unsigned n;
    logic [31:0] cd, hd;
    logic        hwin;
`ifdef ARB_STARVE_GUARD_EN
    n = 15;
`else
    n = 20;
`endif
    for (int unsigned i = 0; i < n; i++) begin
      step();
      cd = $urandom; hd = $urandom;
      drive(1, 1, 32'h100, cd, 1, 1, 32'h104, hd);
      #2;
`ifdef ARB_STARVE_GUARD_EN
      hwin = ((i % (TB_STARVE + 1)) == TB_STARVE);
`else
      hwin = 1'b0;
`endif
      checks++;
      if (ctl !== (hwin ? 5'b01111 : 5'b10011)) begin
        failures++;
        $display("FAIL starve[cycle %0d] ctl=%b required %b", i + 1, ctl, hwin ? 5'b01111 : 5'b10011);
      end
      if (hwin) ref_mem[32'h104] = hd;
      else      ref_mem[32'h100] = cd;
    end
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    step();
    drive(0, 0, 0, 0, 1, 0, 32'h20, 32'h0);
    #2;
    checks++;
    if (ctl !== 5'b00110) begin
      failures++;
      $display("FAIL rstmid_c1 ctl=%b required 00110", ctl);
    end
    step();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checks++;
    if (rv !== 2'b00 || bus.host_rdata !== 32'h0 || ctl !== 5'b00000) begin
      failures++;
      $display("FAIL rstmid_c2 rv=%b hrdata=%h ctl=%b required rv=00 hrdata=0 ctl=00000", rv, bus.host_rdata, ctl);
    end
    step();
    reset = 1'b0;
    #2;
    checks++;
    if ({ctl, rv, bus.cpu_rdata, bus.host_rdata, bus.mem_addr, bus.mem_wdata} !== '0) begin
      failures++;
      $display("FAIL rstmid_c3 ctl=%b rv=%b (all required 0)", ctl, rv);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [8] = '{32'h0, 32'h4, 32'h8, 32'h10, 32'h20, 32'h40, 32'h100, 32'h104};
    logic        cr, cw, hr, hw, cg, hg, fh, we_x;
    logic [31:0] ca, cd, ha, hd, a_x, d_x;
    logic [4:0]  ctl_x;
    int unsigned cnt_m;
    exp_t        e;
    cnt_m = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      cr = ($urandom_range(0, 3) != 0); cw = $urandom_range(0, 1);
      hr = ($urandom_range(0, 3) != 0); hw = $urandom_range(0, 1);
      ca = addrs[$urandom_range(0, 7)]; cd = $urandom;
      ha = addrs[$urandom_range(0, 7)]; hd = $urandom;
      drive(cr, cw, ca, cd, hr, hw, ha, hd);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (rv !== {~e.host, e.host} || bus.cpu_rdata !== (e.host ? 32'h0 : e.data) ||
            bus.host_rdata !== (e.host ? e.data : 32'h0)) begin
          failures++;
          $display("FAIL b2b_return[%0d] rv=%b crdata=%h hrdata=%h required rv=%b data=%h",
                   i, rv, bus.cpu_rdata, bus.host_rdata, {~e.host, e.host}, e.data);
        end
      end else if (rv !== 2'b00 || bus.cpu_rdata !== 32'h0 || bus.host_rdata !== 32'h0) begin
        failures++;
        $display("FAIL b2b_noreturn[%0d] rv=%b required 00", i, rv);
      end
`ifdef ARB_STARVE_GUARD_EN
      fh = hr && (cnt_m == TB_STARVE);
`else
      fh = 1'b0;
`endif
      cg    = cr && !fh;
      hg    = fh || (hr && !cr);
      we_x  = cg ? cw : (hg ? hw : 1'b0);
      a_x   = cg ? ca : (hg ? ha : 32'h0);
      d_x   = cg ? cd : (hg ? hd : 32'h0);
      ctl_x = {cg, cr && !cg, hg, cg | hg, we_x};
      checks++;
      if (ctl !== ctl_x || bus.mem_addr !== a_x || bus.mem_wdata !== d_x) begin
        failures++;
        $display("FAIL b2b_grant[%0d] ctl=%b addr=%h wdata=%h required ctl=%b addr=%h wdata=%h",
                 i, ctl, bus.mem_addr, bus.mem_wdata, ctl_x, a_x, d_x);
      end
      if (cg || hg) begin
        if (!we_x) begin
          e.host = hg; e.data = ref_rd(a_x); exp_q.push_back(e);
        end else begin
          ref_mem[a_x] = d_x;
        end
      end
      cnt_m = (hr && !hg) ? cnt_m + 1 : 0;
    end
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (rv !== {~e.host, e.host} || (e.host ? bus.host_rdata : bus.cpu_rdata) !== e.data) begin
        failures++;
        $display("FAIL b2b_drain rv=%b required rv=%b data=%h", rv, {~e.host, e.host}, e.data);
      end
    end else if (rv !== 2'b00) begin
      failures++;
      $display("FAIL b2b_drain rv=%b required 00", rv);
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_core_rw();
    test_interleave();
    test_collision();
    test_starve();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
